// File: rtl/aes_sched_pkg.sv
// Shared types and defaults for the two-requester AES job scheduler.
package aes_sched_pkg;

  localparam int unsigned AES_W              = 128;
  localparam int unsigned DEFAULT_LATENCY    = 21;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } sched_tag_t;

  typedef struct packed {
    req_id_t          id;
    logic [AES_W-1:0] data;
  } res_entry_t;

endpackage

// File: rtl/aes_sched_fifo.sv
// First-word-fall-through result FIFO with occupancy count.
module aes_sched_fifo
  import aes_sched_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  res_entry_t     wr_data,
  input  logic           rd_en,
  output res_entry_t     rd_data,
  output logic           rd_valid,
  output logic [CW-1:0]  count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  res_entry_t    mem_q [DEPTH];
  res_entry_t    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count_q == CW'(DEPTH));
  assign push     = wr_en;
  assign pop      = rd_en && (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign rd_valid = (count_q != '0);
  assign count    = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Upstream credits must make a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && full && !rd_en));

endmodule

// File: rtl/aes_req_scheduler.sv
// Round-robin scheduler feeding one non-stalling pipelined AES core; results are tagged and buffered.
// Optional macro AES_SCHED_ZEROIZE_EN clears the core inputs on cycles without an issue.
module aes_req_scheduler
  import aes_sched_pkg::*;
#(
  parameter int unsigned LATENCY    = DEFAULT_LATENCY,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [AES_W-1:0] req0_key,
  input  logic [AES_W-1:0] req0_state,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [AES_W-1:0] req1_key,
  input  logic [AES_W-1:0] req1_state,
  output logic [AES_W-1:0] core_key,
  output logic [AES_W-1:0] core_state,
  input  logic [AES_W-1:0] core_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [AES_W-1:0] res_data,
  output logic             res_id,
  output logic             busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic             hs0, hs1, credit_ok, pop;
  logic             last_grant_q, last_grant_d;
  logic [CW-1:0]    inflight_q, inflight_d, fifo_count;
  logic [CW:0]      used;
  logic [AES_W-1:0] core_key_q, core_key_d, core_state_q, core_state_d;
  sched_tag_t       tag_q [LATENCY];
  sched_tag_t       tag_d, tag_out;
  res_entry_t       wr_entry, rd_entry;
  logic             fifo_valid;

  assign used      = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign credit_ok = (used < (CW+1)'(FIFO_DEPTH));

  assign req0_ready = !rst && credit_ok && (!req1_valid || last_grant_q);
  assign req1_ready = !rst && credit_ok && (!req0_valid || !last_grant_q);
  assign hs0        = req0_valid && req0_ready;
  assign hs1        = req1_valid && req1_ready;

  assign tag_out = tag_q[LATENCY-1];

  always_comb begin
    last_grant_d = last_grant_q;
    core_key_d   = core_key_q;
    core_state_d = core_state_q;
    tag_d        = '0;
    inflight_d   = inflight_q;
    if (hs0) begin
      core_key_d   = req0_key;
      core_state_d = req0_state;
      tag_d        = '{valid: 1'b1, id: 1'b0};
      last_grant_d = 1'b0;
    end else if (hs1) begin
      core_key_d   = req1_key;
      core_state_d = req1_state;
      tag_d        = '{valid: 1'b1, id: 1'b1};
      last_grant_d = 1'b1;
    end else begin
`ifdef AES_SCHED_ZEROIZE_EN
      core_key_d   = '0;
      core_state_d = '0;
`endif
    end
    unique case ({tag_d.valid, tag_out.valid})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      core_key_q   <= '0;
      core_state_q <= '0;
      inflight_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      core_key_q   <= core_key_d;
      core_state_q <= core_state_d;
      inflight_q   <= inflight_d;
    end
  end

  // Shadow pipeline: the tag reaches the last stage in step with the core result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LATENCY); i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < int'(LATENCY); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign wr_entry = '{id: tag_out.id, data: core_out};
  assign pop      = fifo_valid && res_ready;

  aes_sched_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (tag_out.valid),
    .wr_data  (wr_entry),
    .rd_en    (pop),
    .rd_data  (rd_entry),
    .rd_valid (fifo_valid),
    .count    (fifo_count)
  );

  assign core_key   = core_key_q;
  assign core_state = core_state_q;
  assign res_valid  = fifo_valid;
  assign res_data   = rd_entry.data;
  assign res_id     = rd_entry.id;
  assign busy       = (inflight_q != '0) || (fifo_count != '0);

endmodule
